// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//   Frame: start(0) + DATA_WIDTH data bits (LSB first) + optional parity + stop(1).
//   Each bit lasts OVERSAMPLE clocks; the bit value is the majority of three
//   samples taken around mid-bit (edge_cnt = OS/2-1, OS/2, OS/2+1).
// Ports:
//   CLK         receiver clock (bit rate = CLK / OVERSAMPLE)
//   RST         asynchronous reset, active low
//   RX_IN       serial line, idles high
//   PAR_EN      1 = frame carries a parity bit (captured at start-bit detect)
//   PAR_TYP     0 = even, 1 = odd parity (captured at start-bit detect)
//   P_DATA      last error-free byte
//   DATA_VALID  one-cycle strobe, P_DATA updated
//   PAR_ERR     one-cycle strobe at end of frame on parity mismatch
//   STP_ERR     one-cycle strobe at end of frame when stop bit sampled low
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam logic [EW-1:0] S0   = EW'(OVERSAMPLE/2 - 1);
  localparam logic [EW-1:0] S1   = EW'(OVERSAMPLE/2);
  localparam logic [EW-1:0] S2   = EW'(OVERSAMPLE/2 + 1);
  localparam logic [EW-1:0] LAST = EW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BLAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [2:0]            samp_q, samp_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic third, maj, bit_end, exp_par;

  // With OVERSAMPLE=4 the third sample lands on the bit's final edge, so it
  // is taken straight from the line instead of from the sample register.
  assign third   = (edge_q == S2) ? RX_IN : samp_q[2];
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & third) | (samp_q[1] & third);
  assign bit_end = (edge_q == LAST);
  // Odd parity is the inverted XOR of the data bits.
  assign exp_par = (^shreg_q) ^ ptyp_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      samp_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      perr_q  <= 1'b0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      samp_q  <= samp_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      perr_q  <= perr_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    samp_d  = samp_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    perr_d  = perr_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + 1'b1;
      if (edge_q == S0) samp_d[0] = RX_IN;
      if (edge_q == S1) samp_d[1] = RX_IN;
      if (edge_q == S2) samp_d[2] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        // Detect edge counts as edge 0 of the start bit.
        if (!RX_IN) begin
          state_d = START;
          edge_d  = EW'(1);
          bit_d   = '0;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = maj ? IDLE : DATA;  // high majority: glitch, drop it silently
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
          if (bit_q == BLAST) begin
            state_d = pen_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (maj != exp_par) perr_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          se_d    = ~maj;
          pe_d    = perr_q;
          if (maj && !perr_q) begin
            dv_d    = 1'b1;
            pdata_d = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = pdata_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (OVERSAMPLE=8): frames are pushed to a
// scoreboard at start-bit time and popped when any output strobe fires.
module tb_uart_rx;
  localparam int OS = 8;

  logic       CLK, RST, RX_IN, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;

  uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  typedef struct {
    logic       dv, pe, se;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nstrobes = 0;
  bit   mon_en = 0;
  logic [7:0] last_good = 8'h00;

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe cycle must match the oldest expected frame.
  always @(negedge CLK) begin
    if (mon_en && RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      exp_t e;
      nstrobes++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, DATA_VALID, PAR_ERR, STP_ERR}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("data_valid", DATA_VALID, e.dv);
        check("par_err",    PAR_ERR,    e.pe);
        check("stp_err",    STP_ERR,    e.se);
        check("p_data",     P_DATA,     e.data);
        check("strobe_cyc", cyc,        e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the last stop edge.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic stopb);
    exp_t e;
    int   f;
    logic par_ok;
    f      = pe ? 11 : 10;
    par_ok = !pe || (pbit == ((^d) ^ pt));
    e.dv   = stopb && par_ok;
    e.pe   = !par_ok;
    e.se   = !stopb;
    if (e.dv) last_good = d;
    e.data = last_good;
    e.cyc  = cyc + 1 + f*OS - 1;
    sb.push_back(e);
    RX_IN = 1'b0; PAR_EN = pe; PAR_TYP = pt;
    repeat (OS) @(negedge CLK);
    // Config must have been latched at start-bit detect; scramble it mid-frame.
    PAR_EN = ~pe; PAR_TYP = ~pt;
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (OS) @(negedge CLK);
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (OS) @(negedge CLK);
    end
    RX_IN = stopb;
    repeat (OS) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge CLK);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    logic [7:0] d55;
    RST = 0; RX_IN = 1; PAR_EN = 0; PAR_TYP = 0;
    d55 = 8'h55;
    repeat (2) @(negedge CLK);
    check("rst_p_data", P_DATA, 8'h00);
    check("rst_dv",     DATA_VALID, 1'b0);
    check("rst_perr",   PAR_ERR, 1'b0);
    check("rst_serr",   STP_ERR, 1'b0);
    RST = 1; mon_en = 1;
    repeat (200) @(negedge CLK);
    check("idle_quiet", nstrobes, 0);

    // Even parity, good frame.
    send_frame(8'hA2, 1'b1, 1'b0, 1'b1, 1'b1);
    RX_IN = 1; drain("drain_a2");
    check("hold_a2", P_DATA, 8'hA2);

    // Parity error: 0x66 has even popcount, parity 1 is wrong.
    send_frame(8'h66, 1'b1, 1'b0, 1'b1, 1'b1);
    RX_IN = 1; drain("drain_perr");

    // Framing error.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    RX_IN = 1; drain("drain_serr");
    repeat (5) @(negedge CLK);

    // Glitch: two low cycles, back to idle by T0+8 where the next frame starts.
    RX_IN = 0;
    repeat (2) @(negedge CLK);
    RX_IN = 1;
    repeat (6) @(negedge CLK);

    // Back-to-back frames, second with odd parity.
    send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hEB, 1'b1, 1'b1, 1'b1, 1'b1);
    RX_IN = 1; drain("drain_b2b");
    check("hold_eb", P_DATA, 8'hEB);

    // Break: stop bit low runs straight into the next start bit.
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    RX_IN = 1; drain("drain_break");

    // Reset mid-frame during data bit 4 of 0x55.
    RX_IN = 0; PAR_EN = 0; PAR_TYP = 0;
    repeat (OS) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d55[i];
      repeat (OS) @(negedge CLK);
    end
    RX_IN = d55[4];
    repeat (3) @(negedge CLK);
    RST = 0;
    repeat (2) @(negedge CLK);
    check("midrst_p_data", P_DATA, 8'h00);
    check("midrst_dv",     DATA_VALID, 1'b0);
    RX_IN = 1; RST = 1; last_good = 8'h00;
    repeat (20) @(negedge CLK);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    RX_IN = 1; drain("drain_81");
    check("hold_81", P_DATA, 8'h81);
    repeat (100) @(negedge CLK);
    check("total_strobes", nstrobes, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
